// File: rtl/fcpu_rob.sv
// 16-entry reorder buffer: in-order allocation from dispatch, out-of-order
// completion from the CDB, in-order commit of the head entry.
module fcpu_rob #(
    parameter int N_ROB_W    = 4,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RSV_ID_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [REG_ADDR_W-1:0] alloc_dst_reg,
    input  logic [2:0]            alloc_type,
    output logic [N_ROB_W-1:0]    alloc_id,
    input  logic                  cdb_valid,
    input  logic [RSV_ID_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]     cdb_data,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic [N_ROB_W-1:0]    commit_id,
    output logic [2:0]            commit_type,
    output logic [REG_ADDR_W-1:0] commit_dst_reg,
    output logic [DATA_W-1:0]     commit_data,
    input  logic                  flush,
    output logic [N_ROB_W:0]      count
);
    localparam int                DEPTH    = 1 << N_ROB_W;
    localparam logic [N_ROB_W:0]  CNT_FULL = (N_ROB_W+1)'(DEPTH);
    localparam logic [N_ROB_W:0]  CNT_ONE  = 1;
    localparam logic [N_ROB_W-1:0] PTR_ONE = 1;

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      done_q;
    logic [2:0]            type_q [DEPTH];
    logic [REG_ADDR_W-1:0] dst_q  [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [N_ROB_W-1:0]    head_q;
    logic [N_ROB_W-1:0]    tail_q;
    logic [N_ROB_W:0]      count_q;

    logic [N_ROB_W-1:0]          cdb_idx;
    logic [RSV_ID_W-N_ROB_W-1:0] cdb_hi;
    logic                        alloc_fire;
    logic                        cdb_fire;
    logic                        commit_fire;

    assign cdb_idx = cdb_tag[N_ROB_W-1:0];
    assign cdb_hi  = cdb_tag[RSV_ID_W-1:N_ROB_W];

    // No bypass from a same-cycle commit: a full buffer only frees up next cycle.
    assign alloc_ready = (count_q != CNT_FULL);
    assign alloc_id    = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Tags with upper bits set belong to other producers and never hit the ROB.
    assign cdb_fire = cdb_valid && (cdb_hi == '0) && valid_q[cdb_idx] && !done_q[cdb_idx];

    assign commit_valid   = valid_q[head_q] && done_q[head_q] && !flush;
    assign commit_fire    = commit_valid && commit_ready;
    assign commit_id      = head_q;
    assign commit_type    = type_q[head_q];
    assign commit_dst_reg = dst_q[head_q];
    assign commit_data    = data_q[head_q];
    assign count          = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i] <= '0;
                dst_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + PTR_ONE;
            end
            if (cdb_fire) begin
                done_q[cdb_idx] <= 1'b1;
                data_q[cdb_idx] <= cdb_data;
            end
            // Allocation is written last so it wins over a CDB hit on the same index.
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                type_q[tail_q]  <= alloc_type;
                dst_q[tail_q]   <= alloc_dst_reg;
                tail_q          <= tail_q + PTR_ONE;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fcpu_rob.sv
// Bench for fcpu_rob: reference model + commit scoreboard checked every cycle,
// plus directed scenarios with fixed expected values.
module tb_fcpu_rob;
    localparam int N_ROB_W = 4, DATA_W = 32, REG_ADDR_W = 5, RSV_ID_W = 5;
    localparam int DEPTH = 16;

    logic                  clk;
    logic                  rst;
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [REG_ADDR_W-1:0] alloc_dst_reg;
    logic [2:0]            alloc_type;
    logic [N_ROB_W-1:0]    alloc_id;
    logic                  cdb_valid;
    logic [RSV_ID_W-1:0]   cdb_tag;
    logic [DATA_W-1:0]     cdb_data;
    logic                  commit_valid;
    logic                  commit_ready;
    logic [N_ROB_W-1:0]    commit_id;
    logic [2:0]            commit_type;
    logic [REG_ADDR_W-1:0] commit_dst_reg;
    logic [DATA_W-1:0]     commit_data;
    logic                  flush;
    logic [N_ROB_W:0]      count;

    fcpu_rob #(
        .N_ROB_W(N_ROB_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .RSV_ID_W(RSV_ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_dst_reg(alloc_dst_reg), .alloc_type(alloc_type), .alloc_id(alloc_id),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_id(commit_id),
        .commit_type(commit_type), .commit_dst_reg(commit_dst_reg), .commit_data(commit_data),
        .flush(flush), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit                    m_valid [DEPTH];
    bit                    m_done  [DEPTH];
    logic [2:0]            m_type  [DEPTH];
    logic [REG_ADDR_W-1:0] m_dst   [DEPTH];
    logic [DATA_W-1:0]     m_data  [DEPTH];
    logic [N_ROB_W-1:0]    m_head, m_tail;
    int                    m_count;
    int                    exp_q[$];
    logic [DATA_W-1:0]     commit_log[$];
    bit                    mon_cv, mon_alloc, mon_wr;
    int                    mon_id;
    logic [N_ROB_W-1:0]    mon_ci;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b0;
        end
        m_head  = '0;
        m_tail  = '0;
        m_count = 0;
        exp_q.delete();
    endtask

    // Outputs are checked mid-cycle; the model then advances to the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            model_clear();
            for (int i = 0; i < DEPTH; i++) begin
                m_type[i] = '0;
                m_dst[i]  = '0;
                m_data[i] = '0;
            end
        end else begin
            check_eq("count", count, m_count);
            check_eq("alloc_ready", alloc_ready, m_count != DEPTH);
            check_eq("alloc_id", alloc_id, m_tail);
            mon_cv = m_valid[m_head] && m_done[m_head] && !flush;
            check_eq("commit_valid", commit_valid, mon_cv);
            if (mon_cv && commit_ready) begin
                check_eq("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_id = exp_q.pop_front();
                    check_eq("commit_id", commit_id, mon_id);
                    check_eq("commit_dst_reg", commit_dst_reg, m_dst[mon_id]);
                    check_eq("commit_type", commit_type, m_type[mon_id]);
                    check_eq("commit_data", commit_data, m_data[mon_id]);
                end
                commit_log.push_back(commit_data);
            end
            if (flush) begin
                model_clear();
            end else begin
                mon_alloc = alloc_valid && (m_count != DEPTH);
                mon_ci    = cdb_tag[N_ROB_W-1:0];
                mon_wr    = cdb_valid && (cdb_tag[RSV_ID_W-1] == 1'b0) && m_valid[mon_ci] && !m_done[mon_ci];
                if (mon_cv && commit_ready) begin
                    m_valid[m_head] = 1'b0;
                    m_done[m_head]  = 1'b0;
                    m_head++;
                    m_count--;
                end
                if (mon_wr) begin
                    m_done[mon_ci] = 1'b1;
                    m_data[mon_ci] = cdb_data;
                end
                if (mon_alloc) begin
                    m_valid[m_tail] = 1'b1;
                    m_done[m_tail]  = 1'b0;
                    m_type[m_tail]  = alloc_type;
                    m_dst[m_tail]   = alloc_dst_reg;
                    exp_q.push_back(int'(m_tail));
                    m_tail++;
                    m_count++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_dst_reg = '0; alloc_type = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        commit_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_alloc_ready", alloc_ready, 1);
        check_eq("rst_alloc_id", alloc_id, 0);
        check_eq("rst_commit_valid", commit_valid, 0);
        check_eq("rst_commit_id", commit_id, 0);
        check_eq("rst_commit_type", commit_type, 0);
        check_eq("rst_commit_dst", commit_dst_reg, 0);
        check_eq("rst_commit_data", commit_data, 0);
        check_eq("rst_count", count, 0);

        // Single instruction, minimum latency
        tick();
        alloc_valid = 1'b1; alloc_dst_reg = 5'd3; alloc_type = 3'd0; commit_ready = 1'b1;
        #1;
        check_eq("t1_alloc_id", alloc_id, 0);
        tick();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd0; cdb_data = 32'h1234_5678;
        #1;
        check_eq("t1_cv_before", commit_valid, 0);
        check_eq("t1_count1", count, 1);
        tick();
        cdb_valid = 1'b0;
        #1;
        check_eq("t1_cv", commit_valid, 1);
        check_eq("t1_dst", commit_dst_reg, 3);
        check_eq("t1_data", commit_data, 32'h1234_5678);
        tick();
        check_eq("t1_count0", count, 0);
        check_eq("t1_log_n", commit_log.size(), 1);
        if (commit_log.size() == 1) check_eq("t1_log0", commit_log[0], 32'h1234_5678);

        // Fill to 16 entries, then try a 17th
        do_flush();
        commit_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1; alloc_dst_reg = 5'(i); alloc_type = 3'(i % 8);
            #1;
            check_eq("t2_alloc_id", alloc_id, i);
            tick();
        end
        #1;
        check_eq("t2_full_ready", alloc_ready, 0);
        check_eq("t2_full_count", count, 16);
        check_eq("t2_wrap_id", alloc_id, 0);
        tick();
        check_eq("t2_17th_count", count, 16);
        alloc_valid = 1'b0;

        // Full with head done: pop first, allocate on the following cycle
        cdb_valid = 1'b1; cdb_tag = 5'd0; cdb_data = 32'h100;
        tick();
        cdb_valid = 1'b0;
        alloc_valid = 1'b1; alloc_dst_reg = 5'd7; alloc_type = 3'd3; commit_ready = 1'b1;
        #1;
        check_eq("t4_cv", commit_valid, 1);
        check_eq("t4_ready0", alloc_ready, 0);
        tick();
        check_eq("t4_count15", count, 15);
        check_eq("t4_ready1", alloc_ready, 1);
        check_eq("t4_alloc_id", alloc_id, 0);
        tick();
        alloc_valid = 1'b0;
        #1;
        check_eq("t4_count16", count, 16);
        check_eq("t4_alloc_id_next", alloc_id, 1);
        check_eq("t4_log_last", commit_log[commit_log.size()-1], 32'h100);

        // Out-of-order completion, in-order commit
        do_flush();
        commit_log.delete();
        commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_dst_reg = 5'(10 + i); alloc_type = 3'd1;
            tick();
        end
        alloc_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cdb_valid = 1'b1; cdb_tag = 5'(2 - k); cdb_data = 32'(12 - k);
            #1;
            check_eq("t3_no_early", commit_valid, 0);
            tick();
        end
        cdb_valid = 1'b0;
        repeat (4) tick();
        check_eq("t3_log_n", commit_log.size(), 3);
        if (commit_log.size() == 3) begin
            check_eq("t3_first", commit_log[0], 32'hA);
            check_eq("t3_second", commit_log[1], 32'hB);
            check_eq("t3_third", commit_log[2], 32'hC);
        end

        // Ignored CDB writes
        do_flush();
        commit_log.delete();
        commit_ready = 1'b0;
        alloc_valid = 1'b1; alloc_dst_reg = 5'd9; alloc_type = 3'd2;
        tick();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'hDEAD;
        tick();
        check_eq("t5_invalid_entry", commit_valid, 0);
        cdb_tag = 5'h10; cdb_data = 32'hBAD;
        tick();
        check_eq("t5_hi_tag", commit_valid, 0);
        cdb_tag = 5'd0; cdb_data = 32'h55;
        tick();
        cdb_data = 32'h66;
        tick();
        cdb_valid = 1'b0;
        #1;
        check_eq("t5_cv", commit_valid, 1);
        check_eq("t5_data", commit_data, 32'h55);
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        check_eq("t5_log_n", commit_log.size(), 1);
        if (commit_log.size() == 1) check_eq("t5_log0", commit_log[0], 32'h55);

        // Flush with a done head and a willing consumer
        do_flush();
        commit_log.delete();
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1; alloc_dst_reg = 5'(20 + i); alloc_type = 3'd4;
            tick();
        end
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd0; cdb_data = 32'h77;
        tick();
        cdb_valid = 1'b0;
        #1;
        check_eq("t6_cv_pre", commit_valid, 1);
        check_eq("t6_count5", count, 5);
        commit_ready = 1'b1; flush = 1'b1;
        #1;
        check_eq("t6_cv_flush", commit_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        check_eq("t6_count0", count, 0);
        check_eq("t6_alloc_id", alloc_id, 0);
        check_eq("t6_cv_after", commit_valid, 0);
        check_eq("t6_log_n", commit_log.size(), 0);

        // Random mixed traffic, checked by the model every cycle
        for (int c = 0; c < 400; c++) begin
            alloc_valid   = ($urandom_range(0, 3) != 0);
            alloc_dst_reg = 5'($urandom);
            alloc_type    = 3'($urandom);
            cdb_valid     = ($urandom_range(0, 3) != 0);
            cdb_tag       = ($urandom_range(0, 15) == 0) ? 5'($urandom) : {1'b0, 4'($urandom)};
            cdb_data      = $urandom;
            commit_ready  = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 63) == 0);
            tick();
        end
        alloc_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
